// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: WIDTH-bit add on a shared 1-bit slice, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b, carryout=1 means no borrow).
module serial_adder_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr, b_ld;
  logic [CW-1:0] cnt;
  logic c, c_ld, s_bit, c_bit, last;
`ifdef SERIAL_ADDER_SUB_EN
  // two's-complement subtract: invert B and force the carry-in to 1
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub | carry;
`else
  assign b_ld = b;
  assign c_ld = carry;
`endif
  assign last  = cnt == CW'(WIDTH - 1);
  assign s_bit = a_sr[0] ^ b_sr[0] ^ c;
  assign c_bit = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0]));
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == IDLE) ? (in_valid ? RUN : IDLE) :
               (state == RUN)  ? (last ? DONE : RUN) :
               (state == DONE) ? (out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      cnt   <= '0;
      c     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        a_sr <= a;
        b_sr <= b_ld;
        c    <= c_ld;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        s_sr <= {s_bit, s_sr[WIDTH-1:1]};
        c    <= c_bit;
        cnt  <= cnt + CW'(1);
      end
    end
  end
  assign in_ready  = state == IDLE && !rst;
  assign out_valid = state == DONE;
  assign busy      = state == RUN || state == DONE;
  assign sum       = s_sr;
  assign carryout  = c;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of a WIDTH=4 and a WIDTH=8 instance with immediate assertions.
module tb_serial_adder_ctrl;
  logic clk = 0, rst = 1;
  logic iv4 = 0, or4 = 1, c4 = 0, sub4 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic ir4, ov4, co4, bz4;
  logic [3:0] s4;
  logic iv8 = 0, or8 = 1, c8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic ir8, ov8, co8, bz8;
  logic [7:0] s8;
  int n_cmp = 0, n_err = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .carry(c4),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub4),
`endif
    .out_valid(ov4), .out_ready(or4), .sum(s4), .carryout(co4), .busy(bz4));

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .carry(c8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(ov8), .out_ready(or8), .sum(s8), .carryout(co8), .busy(bz8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // accept one operation on the WIDTH=4 instance and check it up to DONE;
  // with out_ready high also step into IDLE
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic s,
                      input logic [3:0] es, input logic ec, input string tag);
    int lat;
    a4 = a; b4 = b; c4 = c; sub4 = s; iv4 = 1;
    chk({tag, " in_ready"}, ir4, 1);
    @(posedge clk); #1;
    iv4 = 0; a4 = ~a; b4 = ~b; c4 = ~c; sub4 = ~s;
    chk({tag, " busy"}, bz4, 1);
    lat = 0;
    while (!ov4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, 4);
    chk({tag, " sum"}, s4, es);
    chk({tag, " carryout"}, co4, ec);
    chk({tag, " in_ready in DONE"}, ir4, 0);
    if (or4) begin
      @(posedge clk); #1;
      chk({tag, " out_valid drop"}, ov4, 0);
      chk({tag, " idle in_ready"}, ir4, 1);
    end
  endtask

  initial begin
    int k, acc, prev;
    logic [8:0] e8;
    #100000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k, acc, prev;
    logic [8:0] e8;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", ir4, 0);
    chk("reset out_valid", ov4, 0);
    chk("reset sum", s4, 0);
    chk("reset carryout", co4, 0);
    chk("reset busy", bz4, 0);
    rst = 0;
    #1;
    chk("post-reset in_ready", ir4, 1);

    run4(4'd7, 4'd9, 1'b0, 1'b0, 4'd0, 1'b1, "7+9");
    run4(4'd15, 4'd15, 1'b1, 1'b0, 4'd15, 1'b1, "15+15+1");
    run4(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, "0+0");

    or4 = 0;
    run4(4'd2, 4'd3, 1'b1, 1'b0, 4'd6, 1'b0, "bp 2+3+1");
    iv4 = 1; a4 = 4'd1; b4 = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp hold sum", s4, 6);
      chk("bp hold carryout", co4, 0);
      chk("bp in_ready", ir4, 0);
      chk("bp out_valid", ov4, 1);
    end
    iv4 = 0; or4 = 1;
    @(posedge clk); #1;
    chk("bp release out_valid", ov4, 0);
    chk("bp release in_ready", ir4, 1);
    run4(4'd9, 4'd8, 1'b0, 1'b0, 4'd1, 1'b1, "after bp 9+8");

    a4 = 4'd5; b4 = 4'd6; c4 = 0; iv4 = 1;
    @(posedge clk); #1;
    iv4 = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("midrun rst out_valid", ov4, 0);
    chk("midrun rst sum", s4, 0);
    chk("midrun rst carryout", co4, 0);
    chk("midrun rst busy", bz4, 0);
    chk("midrun rst in_ready", ir4, 1);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ov4) k++;
    end
    chk("midrun rst no out_valid", k, 0);
    run4(4'd3, 4'd4, 1'b0, 1'b0, 4'd7, 1'b0, "3+4");

`ifdef SERIAL_ADDER_SUB_EN
    run4(4'd5, 4'd3, 1'b0, 1'b1, 4'd2, 1'b1, "5-3");
    run4(4'd3, 4'd5, 1'b0, 1'b1, 4'd14, 1'b0, "3-5");
    run4(4'd5, 4'd3, 1'b1, 1'b0, 4'd9, 1'b0, "sub=0 5+3+1");
`endif

    prev = 0;
    for (int i = 0; i < 16; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      e8 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
      iv8 = 1;
      chk("b2b in_ready", ir8, 1);
      @(posedge clk); #1;
      acc = cyc;
      iv8 = 0;
      if (i > 0) chk("b2b interval", acc - prev, 10);
      prev = acc;
      k = 0;
      while (!ov8 && k < 30) begin
        @(posedge clk); #1;
        k++;
      end
      chk("b2b latency", k, 8);
      chk("b2b result", {co8, s8}, e8);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
